rx_buf_ctl: RTL
===============

// Module: rx_buf_ctl
// PURPOSE
//  Buffer controller behind the UART receiver core.
//  - Captures each byte the RX core reports (rx_dout / rx_dout_rdy pulse) into an internal FIFO.
//  - Presents bytes to the consumer with a valid/ready read handshake.
//  - Flags overrun when a byte arrives while the FIFO is full.
//  - Flags an idle timeout when buffered data sits with no new byte for TMO_TICKS baud ticks.
// PARAMETERS
//  DEPTH      16   FIFO entries; power of two, >= 2
//  ADDR_W     4    log2(DEPTH)
//  TMO_TICKS  160  bclk ticks with no push before tmo asserts (~10 bit times at 16x oversampling); >= 1
//  TMO_W      8    timeout counter width; must hold TMO_TICKS
// PORTS
//  clk          in   1         system clock
//  rst          in   1         asynchronous reset, active-high
//  bclk         in   1         baud-tick enable, one clk wide, shared with the RX core
//  rx_dout      in   8         byte from the RX core
//  rx_dout_rdy  in   1         one-cycle strobe: rx_dout valid
//  dout         out  8         head-of-FIFO byte; 8'h00 when dout_vld=0
//  dout_vld     out  1         FIFO not empty
//  dout_rd      in   1         consumer ready; pop when dout_vld && dout_rd
//  level        out  ADDR_W+1  entries stored, 0..DEPTH
//  full         out  1         level == DEPTH
//  ovr          out  1         sticky overrun flag
//  ovr_clr      in   1         clears ovr
//  tmo          out  1         idle-timeout flag (level signal)
// BEHAVIOUR
//  Reset (async):
//   - Pointers, level, timeout counter and state are cleared.
//   - Outputs after reset: dout=0, dout_vld=0, level=0, full=0, ovr=0, tmo=0.
//   - Memory contents are not reset.
//  Pointers:
//   - wr_ptr and rd_ptr are ADDR_W+1 bits wide and wrap naturally.
//   - level = wr_ptr - rd_ptr. full = level == DEPTH. empty = level == 0.
//  Push:
//   - Occurs when rx_dout_rdy && (!full || pop in the same cycle).
//   - Writes mem[wr_ptr[ADDR_W-1:0]] and increments wr_ptr.
//  Pop:
//   - Occurs when dout_vld && dout_rd; increments rd_ptr.
//   - dout_rd while empty is ignored.
//  Simultaneous push and pop:
//   - Both happen and level is unchanged, including when full.
//   - When empty, the pop is void and only the push happens.
//  Latency:
//   - Byte pushed in cycle N appears on dout with dout_vld=1 in cycle N+1.
//   - dout is show-ahead: it always reflects the head entry.
//   - After a pop, the next entry is on dout in the following cycle.
//  Overrun:
//   - rx_dout_rdy while full with no pop: the byte is dropped, nothing is written, and ovr is set from the next cycle.
//   - ovr holds until ovr_clr.
//   - If set and clear happen in the same cycle, set wins.
//  Timeout FSM (states):
//   - IDLE: level==0, counter=0. Push -> FILL.
//   - FILL: counter increments on each bclk and saturates at TMO_TICKS.
//     - Any push clears the counter to 0, and the push wins over a same-cycle bclk.
//     - counter==TMO_TICKS -> TMO.
//     - FIFO drains to 0 -> IDLE.
//   - TMO: tmo=1.
//     - Push -> FILL with counter=0.
//     - FIFO drains to 0 -> IDLE.
//   - tmo is registered and equals (state==TMO).
//  rx_dout_rdy is assumed to be a single-cycle strobe; back-to-back strobes are legal and push on consecutive cycles.
// TESTING
//  1. Push 0x55 with dout_rd=0 -> next cycle: dout_vld=1, dout=0x55, level=1.
//     Then pulse dout_rd -> dout_vld=0, dout=0x00, level=0.
//  2. Push DEPTH bytes 0x00..0x0F -> full=1, level=16.
//     Push 0xAA -> ovr=1, level stays 16.
//     Read all 16 -> order 0x00..0x0F, no 0xAA.
//     Pulse ovr_clr -> ovr=0.
//  3. Full FIFO, rx_dout_rdy and dout_rd in the same cycle -> level stays 16, no ovr.
//     The new byte is read last.
//  4. Push 1 byte, then 160 bclk pulses with no push -> tmo=1 one cycle after the 160th tick.
//     Push one byte -> tmo=0 and counter restarts.
//     Drain the FIFO -> state IDLE, tmo=0.
//  5. Assert rst mid-stream with level=5 and ovr=1 -> outputs are zero immediately, asynchronously.
//     After release, push 0x3C -> dout=0x3C, level=1.
//  6. ovr_clr in the same cycle as an overrun push -> ovr remains 1.

Source files
------------

// File: rtl/rx_buf_ctl_if.sv
// rx_buf_ctl_if: receive-side byte stream, consumer read handshake and status flags of the UART RX buffer
// master: drives baud tick, RX byte strobe, consumer ready and overrun clear
// slave:  the buffer controller; returns head byte, valid, level, full, overrun and timeout
interface rx_buf_ctl_if #(
  parameter int ADDR_W = 4
);
  logic              bclk;
  logic [7:0]        rx_dout;
  logic              rx_dout_rdy;
  logic [7:0]        dout;
  logic              dout_vld;
  logic              dout_rd;
  logic [ADDR_W:0]   level;
  logic              full;
  logic              ovr;
  logic              ovr_clr;
  logic              tmo;
  modport master (
    output bclk, rx_dout, rx_dout_rdy, dout_rd, ovr_clr,
    input  dout, dout_vld, level, full, ovr, tmo
  );
  modport slave (
    input  bclk, rx_dout, rx_dout_rdy, dout_rd, ovr_clr,
    output dout, dout_vld, level, full, ovr, tmo
  );
endinterface

// File: rtl/rx_buf_ctl.sv
// rx_buf_ctl: FIFO buffer behind the UART receiver with show-ahead read, sticky overrun and idle timeout
// clk, rst    : system clock, asynchronous active-high reset
// bus.bclk    : baud tick enable; bus.rx_dout/rx_dout_rdy : byte strobe from the RX core
// bus.dout/dout_vld/dout_rd : head byte, not-empty, consumer ready (pop on vld && rd)
// bus.level/full : fill level 0..DEPTH; bus.ovr/ovr_clr : sticky overrun and its clear
// bus.tmo     : buffered data has seen TMO_TICKS baud ticks without a new byte
module rx_buf_ctl #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int TMO_TICKS = 160,
  parameter int TMO_W     = 8
) (
  input logic         clk,
  input logic         rst,
  rx_buf_ctl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, TMO} state_t;
  localparam logic [TMO_W-1:0] TMO_CNT  = TMO_W'(TMO_TICKS);
  localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W+1)'(DEPTH);
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr, r_rd_ptr, w_level, w_lvl_nxt;
  logic [TMO_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_tick;
  state_t            r_state, w_state_nxt;
  logic              r_ovr, w_full, w_empty, w_push, w_pop;
  assign w_level   = r_wr_ptr - r_rd_ptr;
  assign w_full    = w_level == FULL_LVL;
  assign w_empty   = w_level == '0;
  assign w_pop     = !w_empty && bus.dout_rd;
  // a full FIFO still accepts a byte when the head leaves in the same cycle
  assign w_push    = bus.rx_dout_rdy && (!w_full || w_pop);
  assign w_lvl_nxt = w_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
  assign bus.dout     = w_empty ? 8'h00 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign bus.dout_vld = !w_empty;
  assign bus.level    = w_level;
  assign bus.full     = w_full;
  assign bus.ovr      = r_ovr;
  assign bus.tmo      = r_state == TMO;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.rx_dout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovr    <= 1'b0;
      r_cnt    <= '0;
      r_state  <= IDLE;
    end else begin
      r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(w_push);
      r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(w_pop);
      r_ovr    <= (bus.rx_dout_rdy && w_full && !w_pop) || (r_ovr && !bus.ovr_clr);
      r_cnt    <= w_cnt_nxt;
      r_state  <= w_state_nxt;
    end
  // saturating tick count; a push always restarts it even with a bclk in the same cycle
  assign w_cnt_tick = w_push ? '0 : (bus.bclk && r_cnt != TMO_CNT) ? r_cnt + 1'b1 : r_cnt;
  // entering TMO on the count's next value makes tmo rise the cycle after the final tick
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = w_push ? FILL : IDLE;
        w_cnt_nxt   = '0;
      end
      FILL: begin
        w_state_nxt = w_lvl_nxt == '0 ? IDLE : w_cnt_tick == TMO_CNT ? TMO : FILL;
        w_cnt_nxt   = w_lvl_nxt == '0 ? '0 : w_cnt_tick;
      end
      TMO: begin
        w_state_nxt = w_lvl_nxt == '0 ? IDLE : w_push ? FILL : TMO;
        w_cnt_nxt   = (w_lvl_nxt == '0 || w_push) ? '0 : r_cnt;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end
endmodule
